// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs little-endian bytes into
// 32-bit words, writes them in order, and holds the CPU off until the load ends.
module imem_loader #(
  parameter int WORDS = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   len_words,
  input  logic          abort,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic [7:0]    checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;

  localparam logic [AW:0] WORDS_L = (AW+1)'(WORDS);

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [7:0]    checksum_q, checksum_d;

  logic start_ok;
  logic accept;
  logic last_word;

  assign start_ok  = start && (len_words != '0) && (len_words <= WORDS_L);
  // abort wins over a byte offered in the same cycle
  assign accept    = (state_q == S_LOAD) && byte_valid && !abort;
  assign last_word = (({1'b0, word_idx_q} + (AW+1)'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_LOAD;
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept && (byte_idx_q == 2'd3) && last_word) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == S_LOAD);
    busy       = (state_q != S_IDLE);
    cpu_hold   = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
  end

  always_comb begin
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start_ok) begin
      len_d      = len_words;
      word_idx_d = '0;
      byte_idx_d = 2'd0;
      asm_d      = '0;
      checksum_d = 8'd0;
    end else if (accept) begin
      checksum_d = checksum_q + byte_in;
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = word_idx_q;
        wr_data_d  = {byte_in, asm_q};
        word_idx_d = word_idx_q + 1'b1;
      end else begin
        asm_d[8*byte_idx_q +: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      checksum_q <= 8'd0;
    end else begin
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      checksum_q <= checksum_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single/full loads, stalls, abort and
// illegal or mid-load events, with hand-computed expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  len_words;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic [7:0]  checksum;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          done_cnt = 0;
  int          done_wr_cnt = 0;
  logic        hold_watch = 1'b0;
  int          hold_drop = 0;

  always #5 clk = ~clk;

  imem_loader #(.WORDS(64), .AW(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len_words(len_words),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (reset_n && done) begin
      done_cnt++;
      if (wr_en) done_wr_cnt++;
    end
    if (hold_watch && !cpu_hold) hold_drop++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) until an edge accepts it.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int i = 0; i < 20 && !got; i++) begin
      if (byte_ready) got = 1;
      step();
    end
    byte_valid = 1'b0;
    if (!got) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic [6:0] n);
    start = 1'b1;
    len_words = n;
    step();
    start = 1'b0;
    len_words = 7'd0;
  endtask

  int base;

  initial begin
    reset_n = 1'b0; start = 1'b0; len_words = 7'd0; abort = 1'b0;
    byte_in = 8'd0; byte_valid = 1'b0;

    // Reset with random inputs on the other pins.
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); len_words = 7'($urandom); abort = 1'($urandom);
      byte_in = 8'($urandom); byte_valid = 1'($urandom);
      step();
    end
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", {26'd0, wr_addr}, 32'd0);
    check("rst_data", wr_data, 32'd0);
    check("rst_csum", {24'd0, checksum}, 32'd0);
    start = 1'b0; len_words = 7'd0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'd0;
    reset_n = 1'b1;
    step();

    // Single word.
    do_start(7'd1);
    check("w1_busy", {31'd0, busy}, 32'd1);
    check("w1_hold", {31'd0, cpu_hold}, 32'd1);
    check("w1_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check("w1_wr_en", {31'd0, wr_en}, 32'd1);
    check("w1_addr", {26'd0, wr_addr}, 32'd0);
    check("w1_data", wr_data, 32'h12345678);
    check("w1_done", {31'd0, done}, 32'd1);
    check("w1_ready_fin", {31'd0, byte_ready}, 32'd0);
    check("w1_csum", {24'd0, checksum}, 32'h14);
    step();
    check("w1_busy_low", {31'd0, busy}, 32'd0);
    check("w1_wr_en_low", {31'd0, wr_en}, 32'd0);
    check("w1_done_low", {31'd0, done}, 32'd0);

    // Full memory, 256 continuous bytes.
    wa_q.delete(); wd_q.delete(); done_cnt = 0; done_wr_cnt = 0;
    do_start(7'd64);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    check("full_done_now", {31'd0, done}, 32'd1);
    repeat (4) step();
    check("full_writes", wa_q.size(), 32'd64);
    check("full_done_cnt", done_cnt, 32'd1);
    check("full_done_with_wr", done_wr_cnt, 32'd1);
    check("full_csum", {24'd0, checksum}, 32'h80);
    check("full_busy", {31'd0, busy}, 32'd0);
    if (wa_q.size() == 64) begin
      check("full_addr1_data", wd_q[1], 32'h07060504);
      for (int w = 0; w < 64; w++) begin
        logic [7:0] b0;
        b0 = 8'(4 * w);
        check($sformatf("full_addr%0d", w), {26'd0, wa_q[w]}, w);
        check($sformatf("full_data%0d", w), wd_q[w], {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
      end
    end

    // Stalled stream.
    wa_q.delete(); wd_q.delete(); done_cnt = 0; hold_drop = 0;
    do_start(7'd2);
    hold_watch = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      if (i != 0) repeat (gap) step();
      send_byte(8'(8'h11 * (i + 1)));
    end
    hold_watch = 1'b0;
    step();
    check("stall_writes", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      check("stall_addr0", {26'd0, wa_q[0]}, 32'd0);
      check("stall_data0", wd_q[0], 32'h44332211);
      check("stall_addr1", {26'd0, wa_q[1]}, 32'd1);
      check("stall_data1", wd_q[1], 32'h88776655);
    end
    check("stall_hold_drops", hold_drop, 32'd0);
    check("stall_done_cnt", done_cnt, 32'd1);
    check("stall_csum", {24'd0, checksum}, 32'h64);

    // Abort on the 7th byte.
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    do_start(7'd3);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    abort = 1'b1; byte_valid = 1'b1; byte_in = 8'h07;
    step();
    abort = 1'b0; byte_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) step();
    check("abort_writes", wa_q.size(), 32'd1);
    if (wa_q.size() == 1) check("abort_data0", wd_q[0], 32'h04030201);
    check("abort_done_cnt", done_cnt, 32'd0);
    check("abort_csum", {24'd0, checksum}, 32'h15);

    // Illegal lengths are ignored.
    do_start(7'd0);
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_csum", {24'd0, checksum}, 32'h15);
    do_start(7'd65);
    check("len65_busy", {31'd0, busy}, 32'd0);
    check("len65_ready", {31'd0, byte_ready}, 32'd0);

    // start during LOAD does not relatch length.
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    do_start(7'd2);
    send_byte(8'hA0); send_byte(8'hA1);
    do_start(7'd1);
    check("reld_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hA2); send_byte(8'hA3);
    check("reld_wr_en", {31'd0, wr_en}, 32'd1);
    check("reld_data", wr_data, 32'hA3A2A1A0);
    check("reld_no_done", {31'd0, done}, 32'd0);
    check("reld_busy2", {31'd0, busy}, 32'd1);
    check("reld_csum", {24'd0, checksum}, 32'h86);

    // Reset mid-word.
    send_byte(8'hB0); send_byte(8'hB1);
    base = wa_q.size();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mrst_csum", {24'd0, checksum}, 32'd0);
    repeat (3) step();
    check("mrst_no_write", wa_q.size(), base);
    check("mrst_done_cnt", done_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
